fir_input_feeder: RTL and testbench

//  Upstream stage of FIR_filter: buffers a free-running stream of WIDTH-bit samples and issues

---
 rtl/fir_feeder_pkg.sv | 14 +
 rtl/fir_sample_fifo.sv | 56 +++++
 rtl/fir_input_feeder.sv | 109 ++++++++++
 tb/tb_fir_input_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_feeder_pkg.sv
// Shared types for the FIR input feeder: sample type and issue FSM states.
package fir_feeder_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    WAIT    = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous first-word fall-through sample FIFO; occupancy tracked by level.
module fir_sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fir_input_feeder.sv
// Buffers a free-running sample stream and issues samples one at a time to FIR_filter.
module fir_input_feeder
  import fir_feeder_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [WIDTH-1:0]       FIR_input,
  output logic                   input_valid,
  input  logic                   ready_for_input,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            samples_sent
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  feeder_state_t     state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              seen_low_q, seen_low_d;
  logic [WIDTH-1:0]  fir_q, fir_d;
  logic [15:0]       sent_q, sent_d;
  logic              valid_q, valid_d;

  logic              fifo_pop_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_dout;

  // A push is refused whenever the FIFO is full, even on a pop edge.
  assign s_ready = ~fifo_full;

  fir_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (s_valid & s_ready),
    .pop   (fifo_pop_c),
    .din   (s_data),
    .dout  (fifo_dout),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State, hold counter, handshake flag and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      seen_low_q <= 1'b0;
      fir_q      <= '0;
      sent_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      seen_low_q <= seen_low_d;
      fir_q      <= fir_d;
      sent_q     <= sent_d;
      valid_q    <= valid_d;
    end
  end

  // Issue FSM: pop when filter idles, hold input_valid, then wait for the filter to finish.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    seen_low_d = seen_low_q;
    fir_d      = fir_q;
    sent_d     = sent_q;
    fifo_pop_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && ready_for_input) begin
          fifo_pop_c = 1'b1;
          fir_d      = fifo_dout;
          hold_d     = HOLD_W'(HOLD_CYCLES - 1);
          seen_low_d = 1'b0;
          sent_d     = sent_q + 16'd1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (!ready_for_input) seen_low_d = 1'b1;
        if (hold_q == '0) state_d = WAIT;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      WAIT: begin
        if (!ready_for_input) seen_low_d = 1'b1;
        if (seen_low_q && ready_for_input) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == PRESENT);
  end

  assign FIR_input    = fir_q;
  assign input_valid  = valid_q;
  assign samples_sent = sent_q;

endmodule

// File: tb/tb_fir_input_feeder.sv
// Directed bench for fir_input_feeder with a behavioural FIR_filter handshake model.
module tb_fir_input_feeder;
  import fir_feeder_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned HOLD  = 3;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset;
  sample_t          s_data;
  logic             s_valid;
  logic             s_ready;
  sample_t          fir_input;
  logic             input_valid;
  logic             rfi = 1'b0;
  logic [LVL_W-1:0] level;
  logic [15:0]      samples_sent;

  int      checks = 0;
  int      errors = 0;
  sample_t exp_q[$];
  int      recv_cnt = 0;
  int      pushed = 0;
  bit      hold_ready = 1'b0;
  int      busy = 0;
  bit      iv_prev = 1'b0;
  int      hl = 0;
  sample_t last_issued = '0;

  always #5 clk = ~clk;

  fir_input_feeder #(
    .WIDTH       (16),
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .FIR_input       (fir_input),
    .input_valid     (input_valid),
    .ready_for_input (rfi),
    .level           (level),
    .samples_sent    (samples_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer, pulse-length checker and filter handshake model.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      iv_prev = 1'b0;
      hl      = 0;
      busy    = 0;
      rfi     = !hold_ready;
    end else begin
      if (input_valid && !iv_prev) begin
        chk("issue_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          last_issued = exp_q.pop_front();
          chk("issue_data", 32'(fir_input), 32'(last_issued));
          recv_cnt++;
        end
      end
      if (input_valid) begin
        hl++;
        chk("fir_stable", 32'(fir_input), 32'(last_issued));
      end else if (iv_prev) begin
        chk("valid_len", 32'(hl), 32'(HOLD));
        hl = 0;
      end
      if (hold_ready) begin
        rfi  = 1'b0;
        busy = 0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) rfi = 1'b1;
      end else if (input_valid && rfi) begin
        rfi  = 1'b0;
        busy = 10;
      end else begin
        rfi = 1'b1;
      end
      iv_prev = input_valid;
    end
  end

  task automatic push(input sample_t d);
    bit acc;
    int n;
    n      = 0;
    s_data = d;
    s_valid = 1'b1;
    do begin
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 500);
    s_valid = 1'b0;
    chk("push_accept", 32'(acc), 32'd1);
    if (acc) begin
      exp_q.push_back(d);
      pushed++;
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || input_valid || level != '0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 3000), 32'd1);
    chk({tag, "_sent"}, 32'(samples_sent), 32'(pushed));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iv", 32'(input_valid), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_sent", 32'(samples_sent), 32'd0);
    chk("rst_fir", 32'(fir_input), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single sample: one-cycle latency, 3-cycle pulse, next issue waits for filter.
    push(16'h1234);
    chk("t2_iv_push_edge", 32'(input_valid), 32'd0);
    @(posedge clk); #1;
    chk("t2_iv_next", 32'(input_valid), 32'd1);
    chk("t2_fir", 32'(fir_input), 32'h1234);
    chk("t2_sent", 32'(samples_sent), 32'd1);
    chk("t2_level", 32'(level), 32'd0);
    n = 0;
    while (input_valid && n < 20) begin @(posedge clk); #1; n++; end
    push(16'h2222);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_stalled_level", 32'(level), 32'd1);
    chk("t2_stalled_iv", 32'(input_valid), 32'd0);
    wait_drain("t2");

    // Filter held busy: fill FIFO, ninth sample stalls, then all drain in order.
    hold_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) push(sample_t'(i));
    chk("t3_level_full", 32'(level), 32'd8);
    chk("t3_sready_full", 32'(s_ready), 32'd0);
    s_data  = 16'd9;
    s_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_level_stall", 32'(level), 32'd8);
    chk("t3_sready_stall", 32'(s_ready), 32'd0);
    hold_ready = 1'b0;
    push(16'd9);
    wait_drain("t3");

    // Long stream wrapping the pointers several times.
    for (int i = 0; i < 20; i++) push(16'h0100 + sample_t'(i));
    wait_drain("t4");

    // Full FIFO with a pop edge and s_valid high: push must be refused.
    hold_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push(16'h0500 + sample_t'(i));
    chk("t5_level_full", 32'(level), 32'd8);
    s_data     = 16'hBEEF;
    s_valid    = 1'b1;
    hold_ready = 1'b0;
    n = 0;
    while (level == LVL_W'(8) && n < 50) begin @(posedge clk); #1; n++; end
    s_valid = 1'b0;
    chk("t5_level_after_pop", 32'(level), 32'd7);
    chk("t5_sready_after_pop", 32'(s_ready), 32'd1);
    wait_drain("t5");

    // Reset while presenting a sample, with another sample buffered.
    push(16'hC0DE);
    push(16'hD00D);
    n = 0;
    while (!input_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("t6_reached_present", 32'(input_valid), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_iv", 32'(input_valid), 32'd0);
    chk("t6_rst_sready", 32'(s_ready), 32'd1);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_sent", 32'(samples_sent), 32'd0);
    exp_q.delete();
    pushed = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_idle_iv", 32'(input_valid), 32'd0);
    chk("t6_idle_level", 32'(level), 32'd0);
    chk("t6_idle_fir", 32'(fir_input), 32'd0);
    push(16'hA5A5);
    @(posedge clk); #1;
    chk("t6_issue_iv", 32'(input_valid), 32'd1);
    chk("t6_issue_fir", 32'(fir_input), 32'hA5A5);
    wait_drain("t6");

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
